// File: rtl/uart_rd_pkg.sv
// Shared types and constants for the UART status-read requester.
// Build option: define UART_RD_CSUM_EN to append an XOR checksum byte to every response frame.
package uart_rd_pkg;

   // Requester FSM states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      REQ      = 3'd2,
      WAIT_ACK = 3'd3,
      SEND     = 3'd4
   } state_t;

   // Protocol byte defaults
   localparam logic [7:0] HDR_CMD_DEF  = 8'h55;
   localparam logic [7:0] HDR_RSP_DEF  = 8'hAA;
   localparam logic [7:0] HDR_ERR_DEF  = 8'hAE;
   localparam logic [7:0] ADDR_MIN_DEF = 8'h80;
   localparam logic [7:0] ADDR_MAX_DEF = 8'hE4;
   localparam int         TIMEOUT_CYC_DEF = 1024;

   // Error codes carried in the 32-bit payload of an error frame
   localparam logic [31:0] ERR_TIMEOUT = 32'd1;
   localparam logic [31:0] ERR_PHASE   = 32'd2;
   localparam logic [31:0] ERR_ADDR    = 32'd3;

   // Frame lengths: header, addr, four data bytes, optional checksum
   localparam int FRAME_LEN_BASE = 6;
   localparam int FRAME_LEN_CSUM = 7;
`ifdef UART_RD_CSUM_EN
   localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
   localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

endpackage

// File: rtl/uart_rd_req_ctrl_if.sv
// Bus bundle between the requester and its neighbours: UART RX/TX byte cores and the status read-lock stage.
//
// Handshakes:
//  - rx: rx_valid is a one-cycle strobe; there is no back-pressure, and the byte is lost if it is not taken that cycle.
//  - tx: a byte transfers on a cycle with tx_valid && tx_ready. Once raised, tx_valid and tx_data hold until that cycle.
//  - read-lock: uart_read_req is a toggle. uart_read_addr is stable from the toggle until uart_read_ack toggles to match.
//    status_bus_lock is valid once the acknowledge level equals the request level.
interface uart_rd_req_ctrl_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        uart_read_req;
   logic [7:0]  uart_read_addr;
   logic        uart_read_ack;
   logic [31:0] status_bus_lock;

   modport master (
      input  rx_valid, rx_data, tx_ready, uart_read_ack, status_bus_lock,
      output tx_valid, tx_data, uart_read_req, uart_read_addr
   );

   modport slave (
      output rx_valid, rx_data, tx_ready, uart_read_ack, status_bus_lock,
      input  tx_valid, tx_data, uart_read_req, uart_read_addr
   );
endinterface

// File: rtl/uart_rd_bit_sync.sv
// Generic two-flop synchroniser for a single asynchronous level, async active-low reset to 0.
module uart_rd_bit_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the async level into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rd_req_ctrl.sv
// UART status-read requester: parses 55/addr commands from RX, performs a toggle request/ack
// read against the read-lock stage, and returns a framed response on TX.
// Build option: UART_RD_CSUM_EN adds a trailing XOR checksum byte to every frame.
module uart_rd_req_ctrl
   import uart_rd_pkg::*;
#(
   parameter logic [7:0] HDR_CMD     = HDR_CMD_DEF,
   parameter logic [7:0] HDR_RSP     = HDR_RSP_DEF,
   parameter logic [7:0] HDR_ERR     = HDR_ERR_DEF,
   parameter logic [7:0] ADDR_MIN    = ADDR_MIN_DEF,
   parameter logic [7:0] ADDR_MAX    = ADDR_MAX_DEF,
   parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic               core_clk,
   input  logic               core_rst_n,
   uart_rd_req_ctrl_if.master bus,
   output logic               busy,
   output logic               timeout_flag,
   output state_t             fsm_state
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [2:0]  IDX_LAST = 3'(FRAME_LEN - 1);

   state_t      state;
   state_t      state_next;
   logic        ack_sync;
   logic [15:0] timer;
   logic        timer_done;
   logic        addr_ok;
   logic        phase_ok;
   logic        tx_accept;
   logic [7:0]  addr_q;
   logic [31:0] word_q;
   logic        err_hdr;
   logic [2:0]  idx;
   logic [2:0]  idx_next;
   logic        tx_valid_q;
   logic [7:0]  tx_data_q;
   logic        req_q;
   logic [7:0]  read_addr_q;
   logic        timeout_q;
   logic [7:0]  frame [FRAME_LEN];

   uart_rd_bit_sync u_ack_sync (
      .clk   (core_clk),
      .rst_n (core_rst_n),
      .d     (bus.uart_read_ack),
      .q     (ack_sync)
   );

   assign timer_done = (timer >= TMO_LAST);
   assign addr_ok    = (bus.rx_data >= ADDR_MIN) && (bus.rx_data <= ADDR_MAX);
   assign phase_ok   = (ack_sync == req_q);
   assign tx_accept  = tx_valid_q && bus.tx_ready;
   assign idx_next   = idx + 3'd1;

   assign bus.tx_valid       = tx_valid_q;
   assign bus.tx_data        = tx_data_q;
   assign bus.uart_read_req  = req_q;
   assign bus.uart_read_addr = read_addr_q;
   assign busy               = (state != IDLE);
   assign timeout_flag       = timeout_q;
   assign fsm_state          = state;

   // Assemble the response frame from the captured header kind, address and payload word
   always_comb begin
      frame[0] = err_hdr ? HDR_ERR : HDR_RSP;
      frame[1] = addr_q;
      frame[2] = word_q[31:24];
      frame[3] = word_q[23:16];
      frame[4] = word_q[15:8];
      frame[5] = word_q[7:0];
`ifdef UART_RD_CSUM_EN
      frame[6] = frame[0] ^ frame[1] ^ frame[2] ^ frame[3] ^ frame[4] ^ frame[5];
`endif
   end

   // State register
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) state <= IDLE;
      else             state <= state_next;
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.rx_valid && (bus.rx_data == HDR_CMD)) state_next = ADDR;
         end
         ADDR: begin
            if (bus.rx_valid)    state_next = (addr_ok && phase_ok) ? REQ : SEND;
            else if (timer_done) state_next = IDLE;
         end
         REQ: begin
            state_next = WAIT_ACK;
         end
         WAIT_ACK: begin
            // A matching ack wins over a timeout that expires in the same cycle
            if (phase_ok || timer_done) state_next = SEND;
         end
         SEND: begin
            if (tx_accept && (idx == IDX_LAST)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Per-state cycle timer, saturating, restarted on every state change
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n)               timer <= 16'd0;
      else if (state_next != state)  timer <= 16'd0;
      else if (timer != 16'hFFFF)    timer <= timer + 16'd1;
   end

   // Datapath: address/payload capture, request toggle, timeout flag and TX byte sequencing
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         addr_q      <= 8'd0;
         word_q      <= 32'd0;
         err_hdr     <= 1'b0;
         idx         <= 3'd0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'd0;
         req_q       <= 1'b0;
         read_addr_q <= 8'd0;
         timeout_q   <= 1'b0;
      end else begin
         case (state)
            ADDR: begin
               if (bus.rx_valid) begin
                  addr_q <= bus.rx_data;
                  if (!addr_ok) begin
                     err_hdr <= 1'b1;
                     word_q  <= ERR_ADDR;
                  end else if (!phase_ok) begin
                     // An earlier request is still unacknowledged; issuing another would desync the toggles
                     err_hdr <= 1'b1;
                     word_q  <= ERR_PHASE;
                  end else begin
                     err_hdr <= 1'b0;
                  end
               end
            end
            REQ: begin
               read_addr_q <= addr_q;
               req_q       <= ~req_q;
            end
            WAIT_ACK: begin
               if (phase_ok) begin
                  word_q <= bus.status_bus_lock;
               end else if (timer_done) begin
                  timeout_q <= 1'b1;
                  err_hdr   <= 1'b1;
                  word_q    <= ERR_TIMEOUT;
               end
            end
            SEND: begin
               if (!tx_valid_q) begin
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= frame[idx];
               end else if (bus.tx_ready) begin
                  if (idx == IDX_LAST) begin
                     tx_valid_q <= 1'b0;
                     idx        <= 3'd0;
                  end else begin
                     idx       <= idx_next;
                     tx_data_q <= frame[idx_next];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
